simple_uart_tx: RTL
===================

SIMPLE_UART_TX -- requirements
Module: simple_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, the number of CLK cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the data bits per frame (fixed at 8 for this block).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port fifo_rd_data  input  DATA_WIDTH  head-of-FIFO byte, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_empty  input  1  FIFO holds no data.
REQ-007 SHALL have port fifo_rd_en  output  1  single-cycle pop strobe to the FIFO.
REQ-008 SHALL have port txd  output  1  serial line, idle-high, registered.
REQ-009 SHALL have port busy  output  1  frame in progress.

Function
REQ-010 SHALL send 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 In IDLE with fifo_empty=0, fifo_rd_en SHALL be 1 combinationally in that same cycle; otherwise fifo_rd_en SHALL be 0.
REQ-013 fifo_rd_en SHALL be high for exactly one cycle per frame and never outside IDLE.
REQ-014 On the pop edge: fifo_rd_data latched into an 8-bit shift register, state -> START, txd <= 0, baud counter <= 0, bit index <= 0.
REQ-015 Baud counter SHALL count 0..CLKS_PER_BIT-1; each bit is held on txd for exactly CLKS_PER_BIT cycles.
REQ-016 START -> DATA when counter = CLKS_PER_BIT-1; txd <= shift[0].
REQ-017 In DATA at counter = CLKS_PER_BIT-1: shift right; bit index +1; txd <= next bit; after bit index 7 -> STOP with txd <= 1.
REQ-018 STOP -> IDLE when counter = CLKS_PER_BIT-1; txd stays 1.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles of non-idle line (start edge to end of stop).
REQ-020 Back-to-back frames: exactly one IDLE cycle (txd=1) between the end of the stop bit and the next start bit; period = 10*CLKS_PER_BIT+1 cycles.
REQ-021 fifo_rd_data and fifo_empty SHALL be ignored outside IDLE; FIFO changes mid-frame do not affect the current frame.
REQ-022 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE (including the pop cycle).
REQ-023 Counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits with no overflow at the maximum parameter.

Reset
REQ-024 While RST=1: state=IDLE, txd=1, busy=0, counter=0, bit index=0, shift register=0, all taking effect immediately without waiting for CLK.
REQ-025 While RST=1, fifo_rd_en SHALL be 0 regardless of fifo_empty.
REQ-026 Reset mid-frame SHALL abort the frame; the already-popped byte is discarded, and no extra pop occurs.
REQ-027 After RST deasserts, the first pop SHALL occur on the first cycle in which fifo_empty=0.

Verification (CLKS_PER_BIT=4)
REQ-028 FIFO empty for 100 cycles after reset -> txd=1, busy=0, and fifo_rd_en=0 throughout.
REQ-029 One byte 0x55 -> one fifo_rd_en pulse; txd = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), 4 cycles per bit, 40 cycles total.
REQ-030 0xA5 then 0x3C queued together -> two pops 41 cycles apart; 0x3C bits 0,0,1,1,1,1,0,0 follow 1 idle cycle after the first stop bit.
REQ-031 0x00 and 0xFF -> 0x00 gives a low run of 36 cycles then a 4-cycle stop; 0xFF gives a 4-cycle low start bit then 36 cycles high.
REQ-032 RST asserted mid-data-bit 3, not aligned to CLK -> txd=1 and busy=0 immediately; no pop during reset; after release with FIFO non-empty, a new full frame starts cleanly.
REQ-033 fifo_empty toggles during a frame -> no fifo_rd_en until IDLE, and the frame bits are unchanged.

Source files
------------

// File: rtl/simple_uart_tx_if.sv
// FIFO read-side bundle between the UART transmitter and its byte FIFO.
// The transmitter owns the pop strobe; the FIFO presents its head byte and
// its empty flag.
interface simple_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;

  // Transmitter side: consumes head byte and empty flag, drives the pop.
  modport master (
    input  fifo_rd_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  // FIFO side: presents head byte and empty flag, receives the pop.
  modport slave (
    output fifo_rd_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/simple_uart_tx.sv
// 8N1 UART transmitter fed from a FIFO.
// A byte is popped in the single IDLE cycle that sees a non-empty FIFO, then
// shifted out as start bit, eight data bits LSB first, and stop bit, each held
// for CLKS_PER_BIT clocks. Back-to-back frames are separated by exactly one
// idle-high cycle, the cycle in which the next byte is popped.
module simple_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  simple_uart_tx_if.master fifo,
  output logic             txd,
  output logic             busy
);

  // Counter spans 0..CLKS_PER_BIT-1, so ceil(log2) bits never overflow.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  txd_q,   txd_d;
  logic                  pop;
  logic                  bit_done;

  // The pop is combinational so the FIFO advances on the same edge that
  // captures its head byte; reset gates it so a held reset never pops.
  assign pop       = (state_q == IDLE) && !fifo.fifo_empty && !RST;
  assign bit_done  = (cnt_q == CNT_LAST);

  assign fifo.fifo_rd_en = pop;
  assign txd             = txd_q;
  assign busy            = (state_q != IDLE);

  // Next-state logic: frame sequencing, baud counting and bit shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d = fifo.fifo_rd_data;
          state_d = START;
          txd_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      START: begin
        if (bit_done) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // Bit 1 of the current register becomes bit 0 after the shift.
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        txd_d = 1'b1;
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State register; reset forces an idle-high line at once and drops any
  // byte already taken from the FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule
